// File: rtl/sysserv_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sysserv_arbiter
// Brief    : Round-robin front-end that serialises client commands onto the
//            system-services core and buffers responses in a FWFT FIFO.
//            Optional watchdog: define SYSSERV_ARB_TIMEOUT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module sysserv_arbiter #(
    parameter int          NUM_CH         = 4,
    parameter int          RSP_DEPTH      = 16,
    parameter logic [31:0] TIMEOUT_CYCLES = 32'h2000_0000
) (
    input  logic                CLK,
    input  logic                RESETN,
    input  logic [NUM_CH-1:0]   CH_REQ,
    input  logic [8*NUM_CH-1:0] CH_OPCODE,
    output logic [NUM_CH-1:0]   CH_GNT,
    output logic [NUM_CH-1:0]   CH_DONE,
    output logic [NUM_CH-1:0]   CH_ERR,
    output logic [7:0]          RSP_STATUS,
    input  logic                RSP_RDEN,
    output logic [31:0]         RSP_DATA,
    output logic                RSP_EMPTY,
    output logic                SS_CMD_VALID,
    output logic [7:0]          SS_CMD_OPCODE,
    input  logic                SS_CMD_READY,
    input  logic                SS_RSP_VALID,
    input  logic [31:0]         SS_RSP_DATA,
    input  logic                SS_RSP_LAST,
    input  logic [7:0]          SS_RSP_STATUS,
    output logic                USR_BUSY
);

    localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
    localparam int AW = $clog2(RSP_DEPTH);

    typedef enum logic [1:0] {
        S_IDLE     = 2'd0,
        S_ISSUE    = 2'd1,
        S_WAIT_RSP = 2'd2,
        S_DONE     = 2'd3
    } state_t;

    state_t            state_q, state_d;
    logic [CW-1:0]     owner_q, owner_d;
    logic [CW-1:0]     rr_ptr_q, rr_ptr_d;
    logic [7:0]        opcode_q, opcode_d;
    logic [7:0]        rsp_status_q, rsp_status_d;
    logic [NUM_CH-1:0] gnt_q, gnt_d;
    logic              ovf_q, ovf_d;
    logic              err_q, err_d;
    logic [AW:0]       wr_ptr_q, wr_ptr_d;
    logic [AW:0]       rd_ptr_q, rd_ptr_d;
    logic [31:0]       fifo_mem [RSP_DEPTH];

    logic              fifo_full, fifo_empty, fifo_pop, push_req, fifo_push;
    logic              cmd_valid, tmo_hit;
    logic [NUM_CH-1:0] owner_oh;

    // Round-robin search starting one past the last owner
    logic          arb_found;
    logic [CW-1:0] arb_win, arb_cand;
    int            arb_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_win   = rr_ptr_q;
        arb_cand  = '0;
        arb_idx   = 0;
        for (int i = 1; i <= NUM_CH; i++) begin
            arb_idx = int'(rr_ptr_q) + i;
            if (arb_idx >= NUM_CH) arb_idx = arb_idx - NUM_CH;
            arb_cand = CW'(arb_idx);
            if (!arb_found && CH_REQ[arb_cand]) begin
                arb_found = 1'b1;
                arb_win   = arb_cand;
            end
        end
    end

    assign fifo_empty = (wr_ptr_q == rd_ptr_q);
    assign fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                        (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign fifo_pop   = RSP_RDEN && !fifo_empty;
    assign push_req   = (state_q == S_WAIT_RSP) && SS_RSP_VALID;
    // A pop in the same cycle frees the slot, so a full FIFO still accepts
    assign fifo_push  = push_req && (!fifo_full || fifo_pop);

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        if (fifo_push) wr_ptr_d = wr_ptr_q + (AW+1)'(1);
        if (fifo_pop)  rd_ptr_d = rd_ptr_q + (AW+1)'(1);
    end

    always_ff @(posedge CLK) begin
        if (fifo_push) fifo_mem[wr_ptr_q[AW-1:0]] <= SS_RSP_DATA;
    end

`ifdef SYSSERV_ARB_TIMEOUT_EN
    logic [31:0] tmo_q, tmo_d;

    assign tmo_d   = (state_q == S_WAIT_RSP) ? tmo_q + 32'd1 : 32'd0;
    assign tmo_hit = (state_q == S_WAIT_RSP) && (tmo_q == TIMEOUT_CYCLES - 32'd1);

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) tmo_q <= '0;
        else         tmo_q <= tmo_d;
    end
`else
    assign tmo_hit = 1'b0;
`endif

    // The grant cycle is spent in ISSUE with the command still withheld
    assign cmd_valid = (state_q == S_ISSUE) && (gnt_q == '0);

    always_comb begin
        state_d      = state_q;
        owner_d      = owner_q;
        rr_ptr_d     = rr_ptr_q;
        opcode_d     = opcode_q;
        rsp_status_d = rsp_status_q;
        gnt_d        = '0;
        ovf_d        = ovf_q;
        err_d        = err_q;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    gnt_d    = NUM_CH'(1) << arb_win;
                    owner_d  = arb_win;
                    rr_ptr_d = arb_win;
                    opcode_d = CH_OPCODE[{arb_win, 3'b000} +: 8];
                    ovf_d    = 1'b0;
                    state_d  = S_ISSUE;
                end
            end
            S_ISSUE: begin
                if (cmd_valid && SS_CMD_READY) state_d = S_WAIT_RSP;
            end
            S_WAIT_RSP: begin
                if (push_req && !fifo_push) ovf_d = 1'b1;
                if (SS_RSP_VALID && SS_RSP_LAST) begin
                    state_d      = S_DONE;
                    rsp_status_d = SS_RSP_STATUS;
                    err_d        = (SS_RSP_STATUS != 8'h00) || ovf_d;
                end else if (tmo_hit) begin
                    state_d      = S_DONE;
                    rsp_status_d = 8'hFF;
                    err_d        = 1'b1;
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge RESETN) begin
        if (!RESETN) begin
            state_q      <= S_IDLE;
            owner_q      <= '0;
            rr_ptr_q     <= CW'(NUM_CH - 1);
            opcode_q     <= '0;
            rsp_status_q <= '0;
            gnt_q        <= '0;
            ovf_q        <= 1'b0;
            err_q        <= 1'b0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            rr_ptr_q     <= rr_ptr_d;
            opcode_q     <= opcode_d;
            rsp_status_q <= rsp_status_d;
            gnt_q        <= gnt_d;
            ovf_q        <= ovf_d;
            err_q        <= err_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
        end
    end

    assign owner_oh      = NUM_CH'(1) << owner_q;
    assign CH_GNT        = gnt_q;
    assign CH_DONE       = (state_q == S_DONE) ? owner_oh : '0;
    assign CH_ERR        = ((state_q == S_DONE) && err_q) ? owner_oh : '0;
    assign RSP_STATUS    = rsp_status_q;
    assign RSP_DATA      = fifo_mem[rd_ptr_q[AW-1:0]];
    assign RSP_EMPTY     = fifo_empty;
    assign SS_CMD_VALID  = cmd_valid;
    assign SS_CMD_OPCODE = opcode_q;
    assign USR_BUSY      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: doc/sysserv_arbiter.md
# sysserv_arbiter

Parametrised multi-requester front-end for the PolarFire SoC system-services path. Arbitrates service commands from NUM_CH fabric clients round-robin and issues one command at a time to the system-services core. Buffers the multi-word response in a FIFO and returns completion status to the owning channel. Sits between user logic and the PF_SYSTEM_SERVICES instance's command adapter.

## Interface
- NUM_CH, 4: requester channels, 1..8
- RSP_DEPTH, 16: response FIFO words, power of 2, 4..256
- TIMEOUT_CYCLES, 32'h2000_0000: cycles allowed in WAIT_RSP, ≥2
- CLK  in  1  sole clock; all logic rising-edge
- RESETN  in  1  async active-low reset, asserted async, deasserted synchronously to CLK externally
- CH_REQ  in  NUM_CH  per-channel request level; hold until CH_GNT
- CH_OPCODE  in  8*NUM_CH  per-channel opcode, channel i at [8i+7:8i]; stable while CH_REQ high
- CH_GNT  out  NUM_CH  one-cycle accept pulse, one-hot
- CH_DONE  out  NUM_CH  one-cycle completion pulse to owner
- CH_ERR  out  NUM_CH  valid with CH_DONE: status≠0, timeout, or overflow
- RSP_STATUS  out  8  status of last completed command; held until next completion
- RSP_RDEN  in  1  pop response FIFO
- RSP_DATA  out  32  FIFO head, valid when RSP_EMPTY=0
- RSP_EMPTY  out  1  FIFO empty
- SS_CMD_VALID  out  1  command to service core
- SS_CMD_OPCODE  out  8  opcode, stable while SS_CMD_VALID
- SS_CMD_READY  in  1  core accepts when VALID&READY
- SS_RSP_VALID  in  1  response word strobe
- SS_RSP_DATA  in  32  response word
- SS_RSP_LAST  in  1  final word; SS_RSP_STATUS valid
- SS_RSP_STATUS  in  8  core status, 0 = success
- USR_BUSY  out  1  high in any state other than IDLE

## Operation
- States: IDLE, ISSUE, WAIT_RSP, DONE.
- IDLE: if any CH_REQ, pick first requesting channel at or after rr_ptr+1 (mod NUM_CH). Pulse its CH_GNT, latch owner and opcode, clear overflow flag, go ISSUE. rr_ptr ← owner.
- ISSUE: SS_CMD_VALID=1. On SS_CMD_READY go WAIT_RSP.
- WAIT_RSP: each SS_RSP_VALID pushes SS_RSP_DATA into the FIFO. If the FIFO is full, drop the word and set the overflow flag. A word with SS_RSP_LAST latches SS_RSP_STATUS and goes DONE.
- DONE (1 cycle): CH_DONE[owner]=1, CH_ERR[owner]=(status≠0)|overflow|timeout, RSP_STATUS updated. Go IDLE.
- FIFO: simultaneous push and pop when full succeeds with no drop; pop when empty is ignored. Pointers are log2(RSP_DEPTH)+1 bits and wrap naturally. The FIFO is not flushed between commands; the client drains it.
- SS_RSP_VALID outside WAIT_RSP is ignored.
- A channel dropping CH_REQ before its grant is simply not granted.

## Timing
- Reset values: CH_GNT, CH_DONE, CH_ERR, SS_CMD_VALID, USR_BUSY = 0; RSP_STATUS = 0; SS_CMD_OPCODE = 0; RSP_EMPTY = 1; FIFO pointers = 0; rr_ptr = NUM_CH-1, so channel 0 wins first; state IDLE.
- CH_GNT is registered, one cycle after CH_REQ is sampled in IDLE. SS_CMD_VALID rises on the cycle after CH_GNT.
- Minimum turnaround is 4 cycles: grant, issue with READY already high, response with LAST, DONE. The next grant is possible the cycle after DONE.
- RSP_DATA is first-word-fall-through: valid the cycle after the push.
- RESETN assertion mid-command returns to IDLE immediately, discards FIFO contents, and drops SS_CMD_VALID asynchronously. No CH_DONE is issued.

## Configuration
- SYSSERV_ARB_TIMEOUT_EN defined: a counter runs in WAIT_RSP only, reset on entry. When it reaches TIMEOUT_CYCLES, go DONE with RSP_STATUS=8'hFF and CH_ERR=1. Late SS_RSP words after that point are ignored until the next WAIT_RSP.
- SYSSERV_ARB_TIMEOUT_EN undefined: no counter. WAIT_RSP exits only on SS_RSP_LAST, and TIMEOUT_CYCLES is unused.

## Test plan
- Single channel: CH_REQ[0] with opcode 8'h01, READY=1, three response words 0xA0..0xA2, LAST with status 0. Expect CH_GNT[0] 1 cycle later, CH_DONE[0]=1 with CH_ERR=0, RSP_STATUS=0, FIFO pops A0, A1, A2, then RSP_EMPTY=1.
- Fairness: NUM_CH=4, all CH_REQ held high for 8 commands. Expect grant order 0,1,2,3,0,1,2,3.
- Overflow: RSP_DEPTH=4, no pops, 6 response words with status 0. Expect first 4 words kept, CH_ERR=1, RSP_STATUS=0.
- Error status: LAST with SS_RSP_STATUS=8'h07. Expect CH_ERR[owner]=1 and RSP_STATUS=8'h07.
- Timeout, with macro defined and TIMEOUT_CYCLES=16: no response after accept. Expect DONE after 16 cycles in WAIT_RSP, RSP_STATUS=8'hFF, CH_ERR=1. A late LAST response is ignored.
- Reset in WAIT_RSP after 2 words are pushed. Expect SS_CMD_VALID=0, RSP_EMPTY=1, USR_BUSY=0, no CH_DONE, and next grant goes to channel 0.
